// File: rtl/freq_counter_pkg.sv
// Shared types and default sizes for the frequency counter's binary-to-BCD path.
package freq_counter_pkg;

  typedef logic [3:0] BcdDigit;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } BcdConvState;

  localparam int DEFAULT_BIN_WIDTH = 27;
  localparam int DEFAULT_DIGITS    = 8;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next digit.
import freq_counter_pkg::*;

module bcd_digit_adjust (
  input  BcdDigit digit_in,
  output BcdDigit digit_out
);

  assign digit_out = (digit_in >= BcdDigit'(5)) ? digit_in + BcdDigit'(3) : digit_in;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential shift-add-3 binary to packed BCD converter, one input bit per clock.
// Optional leading-zero blanking flags are enabled with BCD_LEADING_ZERO_BLANK_EN.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | adjusting digits and shifting one binary bit into the BCD field per cycle
// DONE  | loading result registers; done pulses in the following cycle
import freq_counter_pkg::*;

module bin_to_bcd_converter #(
  parameter int BIN_WIDTH = DEFAULT_BIN_WIDTH,
  parameter int DIGITS    = DEFAULT_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  binary,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int WORK_W = DIGITS * 4 + BIN_WIDTH;
  localparam int CNT_W  = $clog2(BIN_WIDTH + 1);

  BcdConvState          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORK_W-1:0]    work_q, work_d;
  logic                 ovf_acc_q, ovf_acc_d;
  logic                 done_q, done_d;
  logic [DIGITS*4-1:0]  bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic [DIGITS-1:0]    blank_q, blank_d;
  logic [DIGITS*4-1:0]  adj_bcd;
  logic [WORK_W-1:0]    adj_work;
  logic [DIGITS-1:0]    blank_calc;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit_in  (work_q[BIN_WIDTH + 4*i +: 4]),
      .digit_out (adj_bcd[4*i +: 4])
    );
  end

  assign adj_work = {adj_bcd, work_q[BIN_WIDTH-1:0]};

`ifdef BCD_LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; a digit is blank while every digit above it is zero.
  always_comb begin : p_blank
    logic zero_run;
    zero_run   = 1'b1;
    blank_calc = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run & (work_q[BIN_WIDTH + 4*i +: 4] == 4'd0);
      blank_calc[i] = zero_run;
    end
  end
`else
  assign blank_calc = '0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    ovf_acc_d = ovf_acc_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    blank_d   = blank_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          work_d    = {{(DIGITS*4){1'b0}}, binary};
          cnt_d     = '0;
          ovf_acc_d = 1'b0;
        end
      end
      SHIFT: begin
        work_d = {adj_work[WORK_W-2:0], 1'b0};
        if (adj_work[WORK_W-1]) ovf_acc_d = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (ovf_acc_q) begin
          bcd_d   = {DIGITS{4'h9}};
          ovf_d   = 1'b1;
          blank_d = '0;
        end else begin
          bcd_d   = work_q[WORK_W-1:BIN_WIDTH];
          ovf_d   = 1'b0;
          blank_d = blank_calc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      ovf_acc_q <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      blank_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      ovf_acc_q <= ovf_acc_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      blank_q   <= blank_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;
  assign blank    = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Self-checking bench for bin_to_bcd_converter: cycle-level reference model plus directed literal checks.
module tb_bin_to_bcd_converter;

  localparam int BW  = 27;
  localparam int DG  = 8;
  localparam int LAT = BW + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [BW-1:0]  binary = '0;
  logic           busy, done, overflow;
  logic [DG*4-1:0] bcd;
  logic [DG-1:0]  blank;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_converter #(.BIN_WIDTH(BW), .DIGITS(DG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .binary(binary),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow), .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain decimal arithmetic on the sampled value.
  function automatic logic [DG*4-1:0] ref_bcd(input longint v);
    logic [DG*4-1:0] r;
    r = '0;
    if (v >= 100_000_000) return {DG{4'h9}};
    for (int i = 0; i < DG; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [DG-1:0] ref_blank(input longint v);
    logic [DG-1:0] r;
    longint p;
    r = '0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    p = 10;
    if (v < 100_000_000) begin
      for (int i = 1; i < DG; i++) begin
        r[i] = (v < p);
        p = p * 10;
      end
    end
`endif
    return r;
  endfunction

  // Cycle model: phase counts edges since start was accepted.
  int              phase;
  longint          val;
  logic            exp_done;
  logic [DG*4-1:0] exp_bcd;
  logic            exp_ovf;
  logic [DG-1:0]   exp_blank;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0; val <= 0; exp_done <= 1'b0;
      exp_bcd <= '0; exp_ovf <= 1'b0; exp_blank <= '0;
    end else begin
      exp_done <= 1'b0;
      if (phase == 0) begin
        if (start) begin
          phase <= 1;
          val   <= longint'(binary);
        end
      end else if (phase == LAT) begin
        phase     <= 0;
        exp_done  <= 1'b1;
        exp_bcd   <= ref_bcd(val);
        exp_ovf   <= (val >= 100_000_000);
        exp_blank <= ref_blank(val);
      end else begin
        phase <= phase + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 64'(busy), 64'(phase != 0));
      check("done", 64'(done), 64'(exp_done));
      check("bcd", 64'(bcd), 64'(exp_bcd));
      check("overflow", 64'(overflow), 64'(exp_ovf));
      check("blank", 64'(blank), 64'(exp_blank));
    end
  end

  task automatic convert(input logic [BW-1:0] v, output int lat);
    binary = v;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      errors++;
      $display("FAIL timeout waiting for done (value %0d)", v);
    end
  endtask

  logic [DG-1:0] bl_407, bl_0;
  int lat, ndone, gap;
  logic [BW-1:0] v;

  initial begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
    bl_407 = 8'b1111_1000;
    bl_0   = 8'b1111_1110;
`else
    bl_407 = '0;
    bl_0   = '0;
`endif
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_bcd", 64'(bcd), 64'd0);
    check("reset_ovf", 64'(overflow), 64'd0);
    check("reset_blank", 64'(blank), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    convert(27'd12_345_678, lat);
    check("latency", 64'(lat), 64'd28);
    check("bcd_12345678", 64'(bcd), 64'h1234_5678);
    check("ovf_12345678", 64'(overflow), 64'd0);

    convert(27'd0, lat);
    check("bcd_zero", 64'(bcd), 64'h0);
    check("ovf_zero", 64'(overflow), 64'd0);
    check("blank_zero", 64'(blank), 64'(bl_0));

    convert(27'd99_999_999, lat);
    check("bcd_max", 64'(bcd), 64'h9999_9999);
    check("ovf_max", 64'(overflow), 64'd0);

    convert(27'h5F5_E100, lat);
    check("bcd_ovf", 64'(bcd), 64'h9999_9999);
    check("ovf_set", 64'(overflow), 64'd1);
    check("blank_ovf", 64'(blank), 64'd0);

    convert(27'd407, lat);
    check("bcd_407", 64'(bcd), 64'h0000_0407);
    check("blank_407", 64'(blank), 64'(bl_407));

    // Reset in the middle of a conversion: no done, outputs cleared.
    binary = 27'd55_555_555;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_bcd", 64'(bcd), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (35) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    convert(27'd87_654_321, lat);
    check("after_rst_bcd", 64'(bcd), 64'h8765_4321);
    check("after_rst_lat", 64'(lat), 64'd28);

    // Start pulses and input changes during a conversion are ignored.
    binary = 27'd24_681_357;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c < 60; c++) begin
      if (c == 5 || c == 20) begin
        start  = 1'b1;
        binary = 27'd11_111_111;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        ndone++;
        check("ignore_bcd", 64'(bcd), 64'h2468_1357);
      end
    end
    start = 1'b0;
    check("ignore_one_done", 64'(ndone), 64'd1);

    // Held start re-triggers back to back.
    binary = 27'd3;
    start  = 1'b1;
    ndone  = 0;
    for (int c = 0; c < 3 * (LAT + 1); c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    check("held_start_rate", 64'(ndone), 64'd3);
    repeat (LAT + 2) @(negedge clk);

    // Random conversions; the compare process checks every cycle.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0: v = BW'($urandom_range(0, 999));
        1: v = BW'($urandom_range(99_999_990, 100_000_010));
        default: v = BW'($urandom_range(0, (1 << BW) - 1));
      endcase
      binary = v;
      start  = 1'b1;
      gap = $urandom_range(1, LAT + 6);
      for (int c = 0; c < gap; c++) begin
        @(negedge clk);
        start  = ($urandom_range(0, 3) == 0);
        binary = BW'($urandom_range(0, (1 << BW) - 1));
      end
      start = 1'b0;
    end
    repeat (LAT + 4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
